// File: rtl/pool2_ctrl.sv
// Pool2 sequencer: one f4 read per cycle in 2x2 window order, no backpressure; f5 write lands RD_LAT+POOL_LAT after a window's last read.
// Define POOL2_WCNT_EN to add the pool2_wcnt per-frame write counter port.
module pool2_ctrl #(
    parameter int IN_W     = 10,
    parameter int IN_H     = 10,
    parameter int F4_AW    = 7,
    parameter int F5_AW    = 5,
    parameter int RD_LAT   = 1,
    parameter int POOL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pool2_start,
    output logic             pool2_busy,
    output logic             pool2_done,
    output logic             f4_ren,
    output logic [F4_AW-1:0] f4_raddr,
    output logic             pool2_clr,
    output logic             f5_wen,
    output logic [F5_AW-1:0] f5_waddr
`ifdef POOL2_WCNT_EN
    ,
    output logic [F5_AW-1:0] pool2_wcnt
`endif
);

    localparam int OW      = IN_W / 2;
    localparam int OH      = IN_H / 2;
    localparam int NWIN    = OW * OH;
    localparam int OXW     = (OW > 1) ? $clog2(OW) : 1;
    localparam int OYW     = (OH > 1) ? $clog2(OH) : 1;
    localparam int TAG_LAT = RD_LAT + POOL_LAT;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       smp_q, smp_d;
    logic [OXW-1:0]   ox_q, ox_d;
    logic [OYW-1:0]   oy_q, oy_d;
    logic             f4_ren_q, f4_ren_d;
    logic [F4_AW-1:0] f4_raddr_q, f4_raddr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clr_q, clr_d;
    logic             f5_wen_q, f5_wen_d;
    logic [F5_AW-1:0] f5_waddr_q, f5_waddr_d;

    logic             first_q [RD_LAT];
    logic             first_d [RD_LAT];
    logic             last_q  [TAG_LAT];
    logic             last_d  [TAG_LAT];
    logic [F5_AW-1:0] widx_q  [TAG_LAT];
    logic [F5_AW-1:0] widx_d  [TAG_LAT];

    logic             issue;
    logic             win_end;
    logic             last_rd;
    logic [F5_AW-1:0] cur_widx;
    logic [F4_AW-1:0] cur_raddr;

    always_comb begin
        win_end   = (smp_q == 2'd3);
        last_rd   = win_end && (ox_q == OXW'(OW - 1)) && (oy_q == OYW'(OH - 1));
        cur_widx  = F5_AW'(int'(oy_q) * OW + int'(ox_q));
        cur_raddr = F4_AW'((2 * int'(oy_q) + int'(smp_q[1])) * IN_W
                           + 2 * int'(ox_q) + int'(smp_q[0]));
    end

    // The read for the current counters is issued in the same cycle start is accepted.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pool2_start) begin
                    state_d = READ;
                    issue   = 1'b1;
                end
            end
            READ: begin
                issue = 1'b1;
                if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (f5_wen_q && (f5_waddr_q == F5_AW'(NWIN - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (pool2_start) begin
                    state_d = READ;
                    issue   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        smp_d = smp_q;
        ox_d  = ox_q;
        oy_d  = oy_q;
        if (issue) begin
            smp_d = smp_q + 2'd1;
            if (win_end) begin
                if (ox_q == OXW'(OW - 1)) begin
                    ox_d = '0;
                    oy_d = (oy_q == OYW'(OH - 1)) ? '0 : oy_q + OYW'(1);
                end else begin
                    ox_d = ox_q + OXW'(1);
                end
            end
        end
    end

    // Stage 0 of the tag pipe is aligned with the registered f4 read.
    always_comb begin
        first_d[0] = issue && (smp_q == 2'd0);
        for (int i = 1; i < RD_LAT; i++) begin
            first_d[i] = first_q[i-1];
        end
        last_d[0] = issue && win_end;
        widx_d[0] = cur_widx;
        for (int i = 1; i < TAG_LAT; i++) begin
            last_d[i] = last_q[i-1];
            widx_d[i] = widx_q[i-1];
        end

        f4_ren_d   = issue;
        f4_raddr_d = issue ? cur_raddr : f4_raddr_q;
        clr_d      = first_q[RD_LAT-1];
        f5_wen_d   = last_q[TAG_LAT-1];
        f5_waddr_d = last_q[TAG_LAT-1] ? widx_q[TAG_LAT-1] : f5_waddr_q;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            smp_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            f4_ren_q   <= 1'b0;
            f4_raddr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
            f5_wen_q   <= 1'b0;
            f5_waddr_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                first_q[i] <= 1'b0;
            end
            for (int i = 0; i < TAG_LAT; i++) begin
                last_q[i] <= 1'b0;
                widx_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            f4_ren_q   <= f4_ren_d;
            f4_raddr_q <= f4_raddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clr_q      <= clr_d;
            f5_wen_q   <= f5_wen_d;
            f5_waddr_q <= f5_waddr_d;
            for (int i = 0; i < RD_LAT; i++) begin
                first_q[i] <= first_d[i];
            end
            for (int i = 0; i < TAG_LAT; i++) begin
                last_q[i] <= last_d[i];
                widx_q[i] <= widx_d[i];
            end
        end
    end

`ifdef POOL2_WCNT_EN
    logic [F5_AW-1:0] wcnt_q, wcnt_d;
    logic             start_acc;

    always_comb begin
        start_acc = pool2_start && ((state_q == IDLE) || (state_q == DONE));
        wcnt_d    = wcnt_q;
        if (start_acc) begin
            wcnt_d = '0;
        end else if (f5_wen_q && (int'(wcnt_q) < NWIN)) begin
            wcnt_d = wcnt_q + F5_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign pool2_wcnt = wcnt_q;
`endif

    assign pool2_busy = busy_q;
    assign pool2_done = done_q;
    assign f4_ren     = f4_ren_q;
    assign f4_raddr   = f4_raddr_q;
    assign pool2_clr  = clr_q;
    assign f5_wen     = f5_wen_q;
    assign f5_waddr   = f5_waddr_q;

endmodule

// File: tb/tb_pool2_ctrl.sv
// Bench for pool2_ctrl: default instance for sequencing/timing, RD_LAT=2 instance with f4 + max-pool models.
module tb_pool2_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start, start2;

    logic       busy, done, ren, clr, wen;
    logic [6:0] raddr;
    logic [4:0] waddr;
    logic       busy2, done2, ren2, clr2, wen2;
    logic [6:0] raddr2;
    logic [4:0] waddr2;
`ifdef POOL2_WCNT_EN
    logic [4:0] wcnt, wcnt2;
`endif

    always #5 clk = ~clk;

    pool2_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .pool2_start(start),
        .pool2_busy(busy), .pool2_done(done),
        .f4_ren(ren), .f4_raddr(raddr), .pool2_clr(clr),
        .f5_wen(wen), .f5_waddr(waddr)
`ifdef POOL2_WCNT_EN
        , .pool2_wcnt(wcnt)
`endif
    );

    pool2_ctrl #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pool2_start(start2),
        .pool2_busy(busy2), .pool2_done(done2),
        .f4_ren(ren2), .f4_raddr(raddr2), .pool2_clr(clr2),
        .f5_wen(wen2), .f5_waddr(waddr2)
`ifdef POOL2_WCNT_EN
        , .pool2_wcnt(wcnt2)
`endif
    );

    // f4 memory returns data = address after 2 cycles; pool unit keeps a running max.
    logic [6:0] d1, rdata, acc;
    logic [6:0] f5mem [32];
    int         nw2 = 0;

    always @(posedge clk) begin
        d1    <= raddr2;
        rdata <= d1;
        if (clr2) acc <= rdata;
        else if (rdata > acc) acc <= rdata;
        if (wen2) begin
            f5mem[waddr2] <= acc;
            nw2           <= nw2 + 1;
        end
    end

    typedef struct {
        int cyc; int ren; int raddr; int clr; int wen; int waddr; int busy; int done;
    } vec_t;
    localparam int NTAB = 18;
    vec_t tab [NTAB];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_addr(input int i);
        int w, s;
        w = i / 4;
        s = i % 4;
        return (2 * (w / 5) + s / 2) * 10 + 2 * (w % 5) + s % 2;
    endfunction

    // Entered just after a posedge; cycle c=0 is the cycle start is driven (T).
    task automatic run_frame(input string tag, input int restart_at, input int ncyc,
                             input bit use_tab, output int nren, output int nwen,
                             output int ndone, output int first_done, output int last_done,
                             output int ren_after_done);
        int wc_exp;
        nren = 0; nwen = 0; ndone = 0; first_done = -1; last_done = -1;
        ren_after_done = -1; wc_exp = 0;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == restart_at);
            @(negedge clk);
            if (use_tab) begin
                for (int t = 0; t < NTAB; t++) begin
                    if (tab[t].cyc == c) begin
                        check($sformatf("%s c%0d ren", tag, c), int'(ren), tab[t].ren);
                        check($sformatf("%s c%0d clr", tag, c), int'(clr), tab[t].clr);
                        check($sformatf("%s c%0d wen", tag, c), int'(wen), tab[t].wen);
                        check($sformatf("%s c%0d busy", tag, c), int'(busy), tab[t].busy);
                        check($sformatf("%s c%0d done", tag, c), int'(done), tab[t].done);
                        if (tab[t].ren != 0)
                            check($sformatf("%s c%0d raddr", tag, c), int'(raddr), tab[t].raddr);
                        if (c >= 6)
                            check($sformatf("%s c%0d waddr", tag, c), int'(waddr), tab[t].waddr);
                    end
                end
            end
            if (ren) begin
                check($sformatf("%s read%0d addr", tag, nren), int'(raddr), exp_addr(nren % 100));
                if (ndone > 0 && ren_after_done < 0) ren_after_done = c;
                nren++;
            end
            if (wen) begin
                check($sformatf("%s write%0d addr", tag, nwen), int'(waddr), nwen % 25);
                nwen++;
            end
            if (done) begin
                if (ndone == 0) first_done = c;
                last_done = c;
                ndone++;
            end
`ifdef POOL2_WCNT_EN
            check($sformatf("%s c%0d wcnt", tag, c), int'(wcnt), wc_exp);
            if (wen) wc_exp++;
            if (start && (done || !busy)) wc_exp = 0;
`endif
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    int nren, nwen, ndone, fdone, ldone, rad, k2, bad;

    initial begin
        tab[0]  = '{0,   0, 0,  0, 0, 0,  0, 0};
        tab[1]  = '{1,   1, 0,  0, 0, 0,  1, 0};
        tab[2]  = '{2,   1, 1,  1, 0, 0,  1, 0};
        tab[3]  = '{3,   1, 10, 0, 0, 0,  1, 0};
        tab[4]  = '{4,   1, 11, 0, 0, 0,  1, 0};
        tab[5]  = '{5,   1, 2,  0, 0, 0,  1, 0};
        tab[6]  = '{6,   1, 3,  1, 1, 0,  1, 0};
        tab[7]  = '{7,   1, 12, 0, 0, 0,  1, 0};
        tab[8]  = '{10,  1, 5,  1, 1, 1,  1, 0};
        tab[9]  = '{22,  1, 21, 1, 1, 4,  1, 0};
        tab[10] = '{97,  1, 88, 0, 0, 22, 1, 0};
        tab[11] = '{98,  1, 89, 1, 1, 23, 1, 0};
        tab[12] = '{99,  1, 98, 0, 0, 23, 1, 0};
        tab[13] = '{100, 1, 99, 0, 0, 23, 1, 0};
        tab[14] = '{101, 0, 0,  0, 0, 23, 1, 0};
        tab[15] = '{102, 0, 0,  0, 1, 24, 1, 0};
        tab[16] = '{103, 0, 0,  0, 0, 24, 1, 1};
        tab[17] = '{104, 0, 0,  0, 0, 24, 0, 0};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset ren", int'(ren), 0);
        check("reset raddr", int'(raddr), 0);
        check("reset clr", int'(clr), 0);
        check("reset wen", int'(wen), 0);
        check("reset waddr", int'(waddr), 0);
`ifdef POOL2_WCNT_EN
        check("reset wcnt", int'(wcnt), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame("single", -1, 108, 1'b1, nren, nwen, ndone, fdone, ldone, rad);
        check("single ren count", nren, 100);
        check("single wen count", nwen, 25);
        check("single done count", ndone, 1);
        check("single done cycle", fdone, 103);

        repeat (3) @(posedge clk);
        #1;
        run_frame("busy_start", 50, 108, 1'b1, nren, nwen, ndone, fdone, ldone, rad);
        check("busy_start ren count", nren, 100);
        check("busy_start wen count", nwen, 25);
        check("busy_start done cycle", fdone, 103);

        repeat (3) @(posedge clk);
        #1;
        run_frame("b2b", 103, 212, 1'b0, nren, nwen, ndone, fdone, ldone, rad);
        check("b2b ren count", nren, 200);
        check("b2b wen count", nwen, 50);
        check("b2b done count", ndone, 2);
        check("b2b first done", fdone, 103);
        check("b2b second done", ldone, 206);
        check("b2b second frame first read", rad, 104);

        // Mid-frame reset: rst_n low during cycle T+40.
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst busy", int'(busy), 0);
        check("midrst ren", int'(ren), 0);
        check("midrst raddr", int'(raddr), 0);
        check("midrst clr", int'(clr), 0);
        check("midrst wen", int'(wen), 0);
        check("midrst waddr", int'(waddr), 0);
        check("midrst done", int'(done), 0);
        bad = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (wen || ren || busy || clr) bad++;
        end
        check("midrst idle activity", bad, 0);
        @(posedge clk);
        #1;
        run_frame("after_rst", -1, 108, 1'b1, nren, nwen, ndone, fdone, ldone, rad);
        check("after_rst ren count", nren, 100);
        check("after_rst wen count", nwen, 25);
        check("after_rst done cycle", fdone, 103);

        // Datapath alignment on the RD_LAT=2 instance.
        k2 = 0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int c = 0; c < 115; c++) begin
            @(negedge clk);
            if (clr2) begin
                check($sformatf("dp clr%0d data", k2), int'(rdata), 20 * (k2 / 5) + 2 * (k2 % 5));
                k2++;
            end
        end
        check("dp clr count", k2, 25);
        check("dp write count", nw2, 25);
        for (int k = 0; k < 25; k++) begin
            check($sformatf("dp f5[%0d]", k), int'(f5mem[k]), 20 * (k / 5) + 2 * (k % 5) + 11);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
